// File: rtl/vga_timing_pkg.sv
// Shared VGA timing constants, the 12-bit colour type and a sync-window helper
// used by the raster generator and the compositor.
package vga_timing_pkg;

    localparam int H_ACTIVE_DEF = 640;
    localparam int H_FP_DEF     = 16;
    localparam int H_SYNC_DEF   = 96;
    localparam int H_BP_DEF     = 48;
    localparam int V_ACTIVE_DEF = 480;
    localparam int V_FP_DEF     = 10;
    localparam int V_SYNC_DEF   = 2;
    localparam int V_BP_DEF     = 33;

    localparam int H_TOTAL_DEF  = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
    localparam int V_TOTAL_DEF  = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;
    localparam int HS_START_DEF = H_ACTIVE_DEF + H_FP_DEF;
    localparam int HS_END_DEF   = HS_START_DEF + H_SYNC_DEF - 1;
    localparam int VS_START_DEF = V_ACTIVE_DEF + V_FP_DEF;
    localparam int VS_END_DEF   = VS_START_DEF + V_SYNC_DEF - 1;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb12_t;

    // True while pos lies in [start, start+width), i.e. inside a sync pulse.
    function automatic logic sync_active(input logic [9:0] pos, input int start,
                                         input int width);
        return (int'(pos) >= start) && (int'(pos) < start + width);
    endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// Pixel-rate divider and raster counters; produces the pixel strobe, active-area flag,
// frame strobe and unregistered active-low syncs.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int CLK_DIV  = 4,
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int H_FP     = H_FP_DEF,
    parameter int H_SYNC   = H_SYNC_DEF,
    parameter int H_BP     = H_BP_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int V_FP     = V_FP_DEF,
    parameter int V_SYNC   = V_SYNC_DEF,
    parameter int V_BP     = V_BP_DEF
) (
    input  logic       clk,
    input  logic       rst,
    output logic       pix_en,
    output logic [9:0] hcount,
    output logic [8:0] raster_y,
    output logic       visible,
    output logic       frame_tick,
    output logic       hs_raw,
    output logic       vs_raw
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DIV_W   = $clog2(CLK_DIV);

    logic [DIV_W-1:0] div;
    logic [9:0]       vcount;
    logic             last_h;
    logic             last_v;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div <= '0;
        end else if (pix_en) begin
            div <= '0;
        end else begin
            div <= div + 1'b1;
        end
    end

    assign pix_en = (div == DIV_W'(CLK_DIV - 1));
    assign last_h = (hcount == 10'(H_TOTAL - 1));
    assign last_v = (vcount == 10'(V_TOTAL - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hcount <= '0;
            vcount <= '0;
        end else if (pix_en) begin
            if (last_h) begin
                hcount <= '0;
                vcount <= last_v ? '0 : vcount + 1'b1;
            end else begin
                hcount <= hcount + 1'b1;
            end
        end
    end

    // Lines above 511 alias onto 0..12 here; they are always blanked by visible.
    assign raster_y   = vcount[8:0];
    assign visible    = (hcount < 10'(H_ACTIVE)) && (vcount < 10'(V_ACTIVE));
    assign frame_tick = pix_en && last_h && last_v;
    assign hs_raw     = !sync_active(hcount, H_ACTIVE + H_FP, H_SYNC);
    assign vs_raw     = !sync_active(vcount, V_ACTIVE + V_FP, V_SYNC);

endmodule

// File: rtl/vga_raster_compositor.sv
// Publishes the raster position to the sprite engines, priority-merges their colours over
// the background and drives registered VGA colour and sync pins.
module vga_raster_compositor
    import vga_timing_pkg::*;
#(
    parameter int          CLK_DIV     = 4,
    parameter int          H_ACTIVE    = H_ACTIVE_DEF,
    parameter int          H_FP        = H_FP_DEF,
    parameter int          H_SYNC      = H_SYNC_DEF,
    parameter int          H_BP        = H_BP_DEF,
    parameter int          V_ACTIVE    = V_ACTIVE_DEF,
    parameter int          V_FP        = V_FP_DEF,
    parameter int          V_SYNC      = V_SYNC_DEF,
    parameter int          V_BP        = V_BP_DEF,
    parameter int          NUM_SPRITES = 4,
    parameter logic [11:0] BG_RGB      = 12'h000
) (
    input  logic                     CLK,
    input  logic                     RESET,
    input  logic [12*NUM_SPRITES-1:0] SPR_RGB,
    input  logic [NUM_SPRITES-1:0]   SPR_VALID,
    output logic [9:0]               RASTER_X,
    output logic [8:0]               RASTER_Y,
    output logic                     VISIBLE,
    output logic                     PIX_EN,
    output logic                     FRAME_TICK,
    output logic [3:0]               VGA_R,
    output logic [3:0]               VGA_G,
    output logic [3:0]               VGA_B,
    output logic                     VGA_HS,
    output logic                     VGA_VS
);

    logic   hs_raw;
    logic   vs_raw;
    rgb12_t merged;
    rgb12_t rgb_p1;
    logic   hs_p1;
    logic   vs_p1;

    vga_timing_gen #(
        .CLK_DIV (CLK_DIV),
        .H_ACTIVE(H_ACTIVE),
        .H_FP    (H_FP),
        .H_SYNC  (H_SYNC),
        .H_BP    (H_BP),
        .V_ACTIVE(V_ACTIVE),
        .V_FP    (V_FP),
        .V_SYNC  (V_SYNC),
        .V_BP    (V_BP)
    ) u_timing (
        .clk       (CLK),
        .rst       (RESET),
        .pix_en    (PIX_EN),
        .hcount    (RASTER_X),
        .raster_y  (RASTER_Y),
        .visible   (VISIBLE),
        .frame_tick(FRAME_TICK),
        .hs_raw    (hs_raw),
        .vs_raw    (vs_raw)
    );

    // Walk from the highest index down so the lowest valid sprite is written last and wins.
    always_comb begin
        merged = rgb12_t'(BG_RGB);
        for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
            if (SPR_VALID[i]) begin
                merged = rgb12_t'(SPR_RGB[12*i +: 12]);
            end
        end
        if (!VISIBLE) begin
            merged = '0;
        end
    end

    // p1: colour and syncs captured from the same counter values, one pixel behind.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            rgb_p1 <= '0;
            hs_p1  <= 1'b1;
            vs_p1  <= 1'b1;
        end else if (PIX_EN) begin
            rgb_p1 <= merged;
            hs_p1  <= hs_raw;
            vs_p1  <= vs_raw;
        end
    end

    assign VGA_R  = rgb_p1.r;
    assign VGA_G  = rgb_p1.g;
    assign VGA_B  = rgb_p1.b;
    assign VGA_HS = hs_p1;
    assign VGA_VS = vs_p1;

endmodule

// File: tb/tb_vga_raster_compositor.sv
// Directed bench for vga_raster_compositor using a reduced raster (200x32 total,
// 160x24 visible, CLK_DIV=4) so whole frames fit in a short run.
module tb_vga_raster_compositor;

    localparam int NS = 4;

    typedef struct {
        int          hx;
        int          vy;
        logic [3:0]  valid;
        logic [47:0] rgb;
        logic        vis;
        logic [11:0] exp_rgb;
        string       name;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst;
    logic [47:0]   spr_rgb;
    logic [NS-1:0] spr_valid;
    logic [9:0]    raster_x;
    logic [8:0]    raster_y;
    logic          visible;
    logic          pix_en;
    logic          frame_tick;
    logic [3:0]    vga_r, vga_g, vga_b;
    logic          vga_hs, vga_vs;

    int n_cmp = 0;
    int n_bad = 0;

    vga_raster_compositor #(
        .CLK_DIV    (4),
        .H_ACTIVE   (160),
        .H_FP       (16),
        .H_SYNC     (16),
        .H_BP       (8),
        .V_ACTIVE   (24),
        .V_FP       (2),
        .V_SYNC     (2),
        .V_BP       (4),
        .NUM_SPRITES(NS),
        .BG_RGB     (12'h00F)
    ) dut (
        .CLK       (clk),
        .RESET     (rst),
        .SPR_RGB   (spr_rgb),
        .SPR_VALID (spr_valid),
        .RASTER_X  (raster_x),
        .RASTER_Y  (raster_y),
        .VISIBLE   (visible),
        .PIX_EN    (pix_en),
        .FRAME_TICK(frame_tick),
        .VGA_R     (vga_r),
        .VGA_G     (vga_g),
        .VGA_B     (vga_b),
        .VGA_HS    (vga_hs),
        .VGA_VS    (vga_vs)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Stops at the negedge where PIX_EN is high at (hx,vy); vy<0 matches any line.
    task automatic wait_pix(input int hx, input int vy, output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 40000; n++) begin
            @(negedge clk);
            if (pix_en && raster_x == hx && (vy < 0 || raster_y == vy)) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_cmp++;
            n_bad++;
            $display("FAIL wait_pix(%0d,%0d): timed out", hx, vy);
        end
    endtask

    function automatic vec_t mk(input int hx, input int vy, input logic [3:0] valid,
                                input logic [47:0] rgb, input logic vis,
                                input logic [11:0] exp_rgb, input string name);
        vec_t v;
        v.hx = hx; v.vy = vy; v.valid = valid; v.rgb = rgb;
        v.vis = vis; v.exp_rgb = exp_rgb; v.name = name;
        return v;
    endfunction

    function automatic logic [11:0] vga_rgb();
        return {vga_r, vga_g, vga_b};
    endfunction

    initial begin
        vec_t vecs[8];
        bit   ok;
        int   cnt;
        int   vs_low;

        vecs[0] = mk(100, 20, 4'b0110, {12'h000, 12'h0F0, 12'hF00, 12'h000}, 1'b1, 12'hF00, "prio_s1_over_s2");
        vecs[1] = mk(101, 20, 4'b0000, {12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF}, 1'b1, 12'h00F, "background");
        vecs[2] = mk(102, 20, 4'b1111, {12'hABC, 12'h456, 12'h789, 12'h123}, 1'b1, 12'h123, "all_valid_s0");
        vecs[3] = mk(103, 20, 4'b1000, {12'hABC, 12'h456, 12'h789, 12'h123}, 1'b1, 12'hABC, "only_s3");
        vecs[4] = mk(180, 20, 4'b1111, {12'hABC, 12'h456, 12'h789, 12'h123}, 1'b0, 12'h000, "h_blank");
        vecs[5] = mk(159, 23, 4'b0100, {12'hABC, 12'h0F0, 12'h789, 12'h123}, 1'b1, 12'h0F0, "last_visible");
        vecs[6] = mk(160, 23, 4'b1111, {12'hABC, 12'h0F0, 12'h789, 12'h123}, 1'b0, 12'h000, "first_h_blank");
        vecs[7] = mk(10, 26, 4'b1111, {12'hABC, 12'h0F0, 12'h789, 12'h123}, 1'b0, 12'h000, "v_blank");

        rst       = 1'b1;
        spr_rgb   = '0;
        spr_valid = '0;
        #23;
        check("reset_rgb", 32'(vga_rgb()), 32'h000);
        check("reset_hs", 32'(vga_hs), 32'h1);
        check("reset_vs", 32'(vga_vs), 32'h1);
        check("reset_pix_en", 32'(pix_en), 32'h0);
        check("reset_x", 32'(raster_x), 32'h0);
        check("reset_y", 32'(raster_y), 32'h0);
        check("reset_tick", 32'(frame_tick), 32'h0);

        @(negedge clk);
        rst = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk);
            #1;
            if (k == 1 || k == 2 || k == 4) check($sformatf("pix_en_clk%0d", k), 32'(pix_en), 32'h0);
            if (k == 3) begin
                check("pix_en_clk3", 32'(pix_en), 32'h1);
                check("x_before_step", 32'(raster_x), 32'h0);
            end
            if (k == 4) begin
                check("x_step1", 32'(raster_x), 32'h1);
                check("first_pixel_bg", 32'(vga_rgb()), 32'h00F);
            end
            if (k == 7) check("pix_en_clk7", 32'(pix_en), 32'h1);
            if (k == 8) check("x_step2", 32'(raster_x), 32'h2);
        end

        wait_pix(176, 0, ok);
        if (ok) begin
            check("hs_before_start", 32'(vga_hs), 32'h1);
            @(posedge clk);
            #1;
            check("hs_start", 32'(vga_hs), 32'h0);
            cnt = 0;
            do begin
                cnt++;
                @(posedge clk);
                #1;
            end while (vga_hs === 1'b0 && cnt < 1000);
            check("hs_low_clks", 32'(cnt), 32'd64);
        end

        foreach (vecs[i]) begin
            spr_valid = vecs[i].valid;
            spr_rgb   = vecs[i].rgb;
            wait_pix(vecs[i].hx, vecs[i].vy, ok);
            if (ok) begin
                check({vecs[i].name, "_visible"}, 32'(visible), 32'(vecs[i].vis));
                @(posedge clk);
                #1;
                check(vecs[i].name, 32'(vga_rgb()), 32'(vecs[i].exp_rgb));
            end
        end

        spr_valid = '0;
        ok = 1'b0;
        for (int n = 0; n < 40000; n++) begin
            @(negedge clk);
            if (frame_tick) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_cmp++;
            n_bad++;
            $display("FAIL frame_tick: never seen");
        end else begin
            check("tick_x", 32'(raster_x), 32'd199);
            check("tick_y", 32'(raster_y), 32'd31);
            @(posedge clk);
            #1;
            check("tick_one_clk", 32'(frame_tick), 32'h0);
            check("wrap_x", 32'(raster_x), 32'h0);
            check("wrap_y", 32'(raster_y), 32'h0);
            cnt    = 0;
            vs_low = 0;
            do begin
                @(negedge clk);
                cnt++;
                if (vga_vs === 1'b0) vs_low++;
            end while (!frame_tick && cnt < 40000);
            check("frame_period_clks", 32'(cnt), 32'd25600);
            check("vs_low_clks", 32'(vs_low), 32'd1600);
        end

        spr_valid = 4'b0001;
        spr_rgb   = {12'h000, 12'h000, 12'h000, 12'hF0F};
        wait_pix(80, 0, ok);
        if (ok) begin
            @(posedge clk);
            #1;
            check("pre_reset_rgb", 32'(vga_rgb()), 32'hF0F);
            #2;
            rst = 1'b1;
            #1;
            check("async_rst_rgb", 32'(vga_rgb()), 32'h000);
            check("async_rst_hs", 32'(vga_hs), 32'h1);
            check("async_rst_vs", 32'(vga_vs), 32'h1);
            check("async_rst_x", 32'(raster_x), 32'h0);
            check("async_rst_pix_en", 32'(pix_en), 32'h0);
            @(negedge clk);
            rst = 1'b0;
            repeat (4) @(posedge clk);
            #1;
            check("restart_x", 32'(raster_x), 32'h1);
            check("restart_y", 32'(raster_y), 32'h0);
            check("restart_rgb", 32'(vga_rgb()), 32'hF0F);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
